// File: rtl/bank_pkg.sv
// Shared types, defaults and width helpers for the bank request front-end.
package bank_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } ctrl_state_e;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_INIT_VALUE = 0;

  function automatic int addr_width(input int byte_aw, input int banks_aw);
    return byte_aw + banks_aw;
  endfunction

  // Bits needed to hold an occupancy value in the range 0..depth.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/bank_req_ctrl_if.sv
// Client-side request and response channels of the bank request front-end.
interface bank_req_ctrl_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
);
  // Both channels use strict valid/ready: a transfer happens on the rising edge
  // where valid && ready; valid never waits on ready, and ready never looks at
  // the payload.
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_wen;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;

  modport master (
    output req_valid, req_wen, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/bank_req_ctrl_rsp_fifo.sv
// Small synchronous FIFO holding read data until the client takes it.
module rsp_fifo
  import bank_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32,
  localparam int CW = count_width(DEPTH),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             pop_eff;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign dout    = mem[rd_ptr];
  assign pop_eff = pop && !empty;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)    wr_ptr <= next_ptr(wr_ptr);
      if (pop_eff) rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop_eff})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bank_req_ctrl.sv
// Front-end for the banked RAM: init sweep, credit-gated requests, and a
// response FIFO that catches the bank's one-cycle-late read data.
module bank_req_ctrl
  import bank_pkg::*;
#(
  parameter int DATA_WIDTH       = DEFAULT_DATA_WIDTH,
  parameter int BYTE_ADDR_WIDTH  = 8,
  parameter int BANKS_ADDR_WIDTH = 2,
  parameter int RSP_DEPTH        = 2,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = DATA_WIDTH'(DEFAULT_INIT_VALUE),
  localparam int ADDR_WIDTH = addr_width(BYTE_ADDR_WIDTH, BANKS_ADDR_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear_req,
  output logic                  init_done,
  output ctrl_state_e           state_dbg,
  bank_req_ctrl_if.slave        bus,
  output logic                  bank_en,
  output logic                  bank_wen,
  output logic [ADDR_WIDTH-1:0] bank_addr,
  output logic [DATA_WIDTH-1:0] bank_din,
  input  logic [DATA_WIDTH-1:0] bank_dout
);

  localparam int CW = count_width(RSP_DEPTH);

  ctrl_state_e           state, state_next;
  logic [ADDR_WIDTH-1:0] init_cnt, init_cnt_next;
  logic                  inflight;
  logic                  accept;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic [CW-1:0]         fifo_count;
  logic [CW:0]           used_slots;

  // A read holds a credit from acceptance until its data sits in the FIFO.
  assign used_slots    = {1'b0, fifo_count} + {{CW{1'b0}}, inflight};
  assign bus.req_ready = (state == READY) && (used_slots < (CW + 1)'(RSP_DEPTH));
  assign accept        = bus.req_valid && bus.req_ready;
  assign init_done     = (state == READY);
  assign state_dbg     = state;
  assign bus.rsp_valid = !fifo_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= INIT;
      init_cnt <= '0;
      inflight <= 1'b0;
    end else begin
      state    <= state_next;
      init_cnt <= init_cnt_next;
      inflight <= accept && !bus.req_wen;
    end
  end

  always_comb begin
    state_next    = state;
    init_cnt_next = init_cnt;
    bank_en       = 1'b0;
    bank_wen      = 1'b0;
    bank_addr     = '0;
    bank_din      = '0;
    unique case (state)
      INIT: begin
        bank_en       = 1'b1;
        bank_wen      = 1'b1;
        bank_addr     = init_cnt;
        bank_din      = INIT_VALUE;
        // The counter wraps to zero on the last write, ready for the next sweep.
        init_cnt_next = init_cnt + 1'b1;
        if (init_cnt == '1) state_next = READY;
      end
      READY: begin
        if (accept) begin
          bank_en   = 1'b1;
          bank_wen  = bus.req_wen;
          bank_addr = bus.req_addr;
          bank_din  = bus.req_wdata;
        end
        if (clear_req) state_next = INIT;
      end
      default: state_next = INIT;
    endcase
  end

  rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_rsp_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (inflight),
    .din   (bank_dout),
    .pop   (bus.rsp_ready),
    .dout  (bus.rsp_rdata),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(inflight && fifo_full))
    else $error("response FIFO push while full");

endmodule
